loader_rom: RTL and testbench
=============================

LOADER_ROM -- requirements
Module: loader_rom

Interface
REQ-001 SHALL provide parameter DEPTH, default 4096: instruction-memory capacity in 16-bit words.
REQ-002 SHALL provide parameter AW, default 15: write-address width, matching the instruction-memory address port.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port rx_data  input  8  incoming program byte (e.g. from UART receiver).
REQ-007 SHALL have port rx_valid  input  1  rx_data holds a valid byte.
REQ-008 SHALL have port rx_ready  output  1  loader can accept a byte this cycle.
REQ-009 SHALL have port wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-010 SHALL have port wr_addr  output  AW  instruction-memory word address.
REQ-011 SHALL have port wr_data  output  16  instruction word to write.
REQ-012 SHALL have port cpu_reset  output  1  holds the CPU in reset while a load is in progress or has failed.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  sticky: last load completed successfully.
REQ-015 SHALL have port error  output  1  sticky: last load failed on an illegal length.

Function
REQ-016 SHALL accept a byte only on a cycle where rx_valid and rx_ready are both 1; rx_data is ignored otherwise.
REQ-017 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
REQ-018 SHALL define the stream format as a 16-bit word count N, big-endian (2 bytes), followed by N words of 2 bytes each, big-endian.
REQ-019 SHALL, on start=1 in IDLE, DONE or ERR, go to LEN_HI, clear done, error and the word counter, and set cpu_reset=1.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL drive rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
REQ-022 SHALL, in LEN_HI, store the accepted byte as N[15:8] and go to LEN_LO.
REQ-023 SHALL, in LEN_LO, store the accepted byte as N[7:0], then go to ERR if N==0 or N>DEPTH, else to DATA_HI.
REQ-024 SHALL, in DATA_HI, store the accepted byte as wr_data[15:8] and go to DATA_LO.
REQ-025 SHALL, in DATA_LO, store the accepted byte as wr_data[7:0] and go to WRITE.
REQ-026 SHALL, in WRITE, drive wr_en=1 for exactly that one cycle with wr_addr = current word index (starting at 0) and wr_data stable.
REQ-027 SHALL, on leaving WRITE, increment the word index and go to DONE if the incremented value equals N, else to DATA_HI.
REQ-028 SHALL hold wr_addr and wr_data stable whenever wr_en=0; their values then are don't-care to the consumer.
REQ-029 SHALL produce write latency of exactly 1 cycle from acceptance of a word's low byte to its wr_en pulse; throughput is at most 1 word per 3 cycles.
REQ-030 SHALL drive busy=1 in LEN_HI through WRITE and busy=0 in IDLE, DONE and ERR.
REQ-031 SHALL drive cpu_reset=1 in LEN_HI through WRITE and in ERR, and cpu_reset=0 in IDLE and DONE.
REQ-032 SHALL set done=1 on entry to DONE; in DONE, done=1 and cpu_reset=0 until the next start or reset.
REQ-033 SHALL set error=1 on entry to ERR; in ERR, wr_en is never asserted.
REQ-034 SHALL never assert wr_en for an address >= N or >= DEPTH.
REQ-035 SHALL have no timeout: a stalled byte stream holds the current state indefinitely.

Reset
REQ-036 SHALL, on reset=1, go to IDLE on that edge, overriding start and any in-flight byte.
REQ-037 SHALL, on reset, set rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=0, busy=0, done=0, error=0 and clear the word counter and N.
REQ-038 SHALL treat a reset mid-load as aborting the load: words already written are not rolled back, and no further wr_en is issued.

Verification
REQ-039 Bench SHALL drive start, then bytes 00 02 AB CD 12 34 -> two wr_en pulses, (addr 0, data ABCD) and (addr 1, data 1234); then done=1, cpu_reset=0, busy=0.
REQ-040 Bench SHALL send length bytes 00 00 -> ERR with error=1, cpu_reset=1, no wr_en pulse; a subsequent start with a valid stream clears error.
REQ-041 Bench SHALL send length 10 01 (4097) -> ERR, error=1, no writes; then length 10 00 followed by 8192 bytes -> 4096 writes, last at addr 0FFF, done=1.
REQ-042 Bench SHALL hold rx_valid=0 for 20 cycles between bytes and toggle it randomly -> identical write sequence; rx_ready=0 during every WRITE cycle.
REQ-043 Bench SHALL assert reset after the first of 3 words is written -> IDLE on the next edge, all outputs at reset values, no further wr_en.
REQ-044 Bench SHALL pulse start while busy -> ignored: counter, N and the write sequence are unchanged.

Source files
------------

// File: rtl/loader_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_rom : byte-stream program loader for the instruction memory   |
// | Stream: 16-bit BE word count N, then N BE 16-bit words.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module loader_rom #(
   parameter int DEPTH = 4096,
   parameter int AW    = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [15:0]   wr_data,
   output logic          cpu_reset,
   output logic          busy,
   output logic          done,
   output logic          error
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_HI  = 3'd1,
      S_LEN_LO  = 3'd2,
      S_DATA_HI = 3'd3,
      S_DATA_LO = 3'd4,
      S_WRITE   = 3'd5,
      S_DONE    = 3'd6,
      S_ERR     = 3'd7
   } state_t;

   state_t          r_state;
   logic [15:0]     r_len;
   logic [15:0]     r_count;
   logic            r_rx_ready;
   logic            r_wr_en;
   logic [AW-1:0]   r_wr_addr;
   logic [15:0]     r_wr_data;
   logic            r_cpu_reset;
   logic            r_busy;
   logic            r_done;
   logic            r_error;

   logic            w_accept;
   logic [15:0]     w_len;
   logic            w_len_bad;
   logic [15:0]     w_next_count;

   assign w_accept     = rx_valid & r_rx_ready;
   assign w_len        = {r_len[15:8], rx_data};
   assign w_len_bad    = (w_len == 16'd0) || ({16'd0, w_len} > DEPTH);
   assign w_next_count = r_count + 16'd1;

   // All outputs are registered and updated together with the state so
   // they always reflect the state the machine is in.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_len       <= 16'd0;
         r_count     <= 16'd0;
         r_rx_ready  <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= 16'd0;
         r_cpu_reset <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state     <= S_LEN_HI;
                  r_count     <= 16'd0;
                  r_rx_ready  <= 1'b1;
                  r_busy      <= 1'b1;
                  r_cpu_reset <= 1'b1;
                  r_done      <= 1'b0;
                  r_error     <= 1'b0;
               end
            end
            S_LEN_HI: begin
               if (w_accept) begin
                  r_len[15:8] <= rx_data;
                  r_state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_accept) begin
                  r_len[7:0] <= rx_data;
                  if (w_len_bad) begin
                     // cpu_reset stays high: a failed load keeps the CPU parked
                     r_state    <= S_ERR;
                     r_rx_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_error    <= 1'b1;
                  end else begin
                     r_state <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (w_accept) begin
                  r_wr_data[15:8] <= rx_data;
                  r_state         <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (w_accept) begin
                  r_wr_data[7:0] <= rx_data;
                  r_wr_addr      <= AW'(r_count);
                  r_wr_en        <= 1'b1;
                  r_rx_ready     <= 1'b0;
                  r_state        <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_count <= w_next_count;
               if (w_next_count == r_len) begin
                  r_state     <= S_DONE;
                  r_busy      <= 1'b0;
                  r_cpu_reset <= 1'b0;
                  r_done      <= 1'b1;
               end else begin
                  r_state    <= S_DATA_HI;
                  r_rx_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rx_ready  = r_rx_ready;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign cpu_reset = r_cpu_reset;
   assign busy      = r_busy;
   assign done      = r_done;
   assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_loader_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_loader_rom : randomized self-checking bench for loader_rom        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_loader_rom;
   localparam int DEPTH = 4096;
   localparam int AW    = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          cpu_reset;
   logic          busy;
   logic          done;
   logic          error;

   loader_rom #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .cpu_reset(cpu_reset),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int rdy_viol = 0;
   logic [7:0]  stim_q[$];
   logic [30:0] exp_q[$];
   logic [30:0] got_q[$];
   bit          exp_err;
   bit          load_ok;
   logic [3:0]  snap;   // {busy, cpu_reset, done, error} right after start

   always @(negedge clk) begin
      if (wr_en) begin
         got_q.push_back({wr_addr, wr_data});
         if (rx_ready) rdy_viol <= rdy_viol + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Reference: stream rules applied directly to the byte list.
   task automatic build_expected();
      int n;
      exp_q.delete();
      n = (int'(stim_q[0]) << 8) | int'(stim_q[1]);
      exp_err = (n == 0) || (n > DEPTH);
      if (!exp_err)
         for (int i = 0; i < n; i++)
            exp_q.push_back({AW'(i), stim_q[2 + 2*i], stim_q[3 + 2*i]});
   endtask

   function automatic int seq_mismatch();
      int m;
      int lim;
      m   = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                          : exp_q.size() - got_q.size();
      lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < lim; i++)
         if (got_q[i] !== exp_q[i]) m++;
      return m;
   endfunction

   // gapmode 0: back-to-back, 1: random idle/garbage, 2: 20 idle cycles
   task automatic send_byte(input logic [7:0] b, input int gapmode, output bit ok);
      int g;
      g  = (gapmode == 2) ? 20 : (gapmode == 1) ? int'($urandom_range(3, 0)) : 0;
      ok = 1'b0;
      for (int k = 0; k < g; k++) begin
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         tick();
      end
      rx_valid = 1'b1;
      rx_data  = b;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (rx_ready) ok = 1'b1;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      rx_valid = 1'b0;
   endtask

   task automatic run_load(input int gapmode, input int start_idx);
      int  nsend;
      bit  ok;
      got_q.delete();
      build_expected();
      pulse_start();
      snap    = {busy, cpu_reset, done, error};
      load_ok = 1'b1;
      nsend   = exp_err ? 2 : stim_q.size();
      for (int i = 0; i < nsend; i++) begin
         if (i == start_idx) pulse_start();
         send_byte(stim_q[i], gapmode, ok);
         if (!ok) begin
            load_ok = 1'b0;
            break;
         end
      end
      for (int t = 0; t < 20 && busy; t++) tick();
      if (busy) load_ok = 1'b0;
   endtask

   task automatic make_stream(input int n);
      stim_q.delete();
      stim_q.push_back(8'(n >> 8));
      stim_q.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) stim_q.push_back(8'($urandom));
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) tick();
      checks++;
      if ({rx_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, done, error} !== '0)
         $display("FAIL reset_outputs: got %h want 0",
                  {rx_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, done, error});
      else passes++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int m;
      stim_q = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
      run_load(0, -1);
      checks++;
      if (snap !== 4'b1100) $display("FAIL basic_start_flags: got %b want 1100", snap);
      else passes++;
      m = seq_mismatch();
      checks++;
      if (!load_ok || m != 0)
         $display("FAIL basic_writes: got %0d writes (%0d bad, ok=%0d) want 2", got_q.size(), m, load_ok);
      else passes++;
      checks++;
      if ({done, cpu_reset, busy, error} !== 4'b1000)
         $display("FAIL basic_status: got %b want 1000", {done, cpu_reset, busy, error});
      else passes++;
   endtask

   task automatic test_len_zero();
      int m;
      stim_q = '{8'h00, 8'h00};
      run_load(0, -1);
      checks++;
      if (!load_ok || got_q.size() != 0 || {error, cpu_reset, done, busy} !== 4'b1100)
         $display("FAIL len_zero: got writes=%0d flags=%b want writes=0 flags=1100",
                  got_q.size(), {error, cpu_reset, done, busy});
      else passes++;
      make_stream(3);
      run_load(1, -1);
      checks++;
      if (snap !== 4'b1100) $display("FAIL err_clear_on_start: got %b want 1100", snap);
      else passes++;
      m = seq_mismatch();
      checks++;
      if (!load_ok || m != 0 || {error, done} !== 2'b01)
         $display("FAIL after_err_load: got bad=%0d flags=%b want bad=0 flags=01", m, {error, done});
      else passes++;
   endtask

   task automatic test_len_bounds();
      int m;
      stim_q = '{8'h10, 8'h01};
      run_load(0, -1);
      checks++;
      if (!load_ok || got_q.size() != 0 || {error, cpu_reset, done} !== 3'b110)
         $display("FAIL len_4097: got writes=%0d flags=%b want writes=0 flags=110",
                  got_q.size(), {error, cpu_reset, done});
      else passes++;
      make_stream(DEPTH);
      run_load(0, -1);
      m = seq_mismatch();
      checks++;
      if (!load_ok || m != 0 || got_q.size() != 4096)
         $display("FAIL full_depth: got %0d writes (%0d bad) want 4096", got_q.size(), m);
      else passes++;
      checks++;
      if (got_q.size() == 0 || got_q[$][30:16] !== 15'h0FFF || done !== 1'b1)
         $display("FAIL full_last_addr: got addr=%h done=%b want 0fff done=1",
                  (got_q.size() == 0) ? 15'h7FFF : got_q[$][30:16], done);
      else passes++;
   endtask

   task automatic test_stall();
      int m;
      make_stream(3);
      run_load(2, -1);
      m = seq_mismatch();
      checks++;
      if (!load_ok || m != 0) $display("FAIL stall20: got %0d bad writes want 0", m);
      else passes++;
      for (int r = 0; r < 6; r++) begin
         make_stream(int'($urandom_range(8, 1)));
         run_load(1, -1);
         m = seq_mismatch();
         checks++;
         if (!load_ok || m != 0 || done !== 1'b1)
            $display("FAIL random_load%0d: got bad=%0d done=%b want bad=0 done=1", r, m, done);
         else passes++;
      end
      checks++;
      if (rdy_viol != 0) $display("FAIL ready_in_write: got %0d want 0", rdy_viol);
      else passes++;
   endtask

   task automatic test_mid_reset();
      bit ok;
      make_stream(3);
      build_expected();
      got_q.delete();
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(stim_q[i], 0, ok);
      for (int t = 0; t < 10 && got_q.size() < 1; t++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({rx_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, done, error} !== '0)
         $display("FAIL midreset_outputs: got %h want 0",
                  {rx_ready, wr_en, wr_addr, wr_data, cpu_reset, busy, done, error});
      else passes++;
      for (int k = 0; k < 12; k++) begin
         rx_valid = 1'b1;
         rx_data  = stim_q[4 + (k % 4)];
         tick();
      end
      rx_valid = 1'b0;
      checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0])
         $display("FAIL midreset_writes: got %0d writes want 1 (first %h)", got_q.size(), exp_q[0]);
      else passes++;
   endtask

   task automatic test_start_busy();
      int m;
      make_stream(4);
      run_load(1, 3);
      m = seq_mismatch();
      checks++;
      if (!load_ok || m != 0 || done !== 1'b1)
         $display("FAIL start_busy: got bad=%0d done=%b want bad=0 done=1", m, done);
      else passes++;
      make_stream(2);
      run_load(0, 1);
      m = seq_mismatch();
      checks++;
      if (!load_ok || m != 0) $display("FAIL start_in_len: got bad=%0d want 0", m);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_len_bounds();
      test_stall();
      test_mid_reset();
      test_start_busy();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
